// File: rtl/rename_reg_file_pkg.sv
// Shared sizing constants and entry layouts for the ARF/RRF rename register file.
package rename_pkg;
  localparam int XLEN      = 32;
  localparam int ARF_DEPTH = 32;
  localparam int RRF_DEPTH = 16;
  localparam int NUM_WAYS  = 2;
  localparam int ARF_AW    = $clog2(ARF_DEPTH);
  localparam int TAG_W     = $clog2(RRF_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic             busy;
    logic [TAG_W-1:0] tag;
  } arf_entry_t;

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic              valid;
    logic              alloc;
    logic [ARF_AW-1:0] dest;
  } rrf_entry_t;
endpackage

// File: rtl/rename_reg_file_if.sv
// Decode/execute/ROB-facing bus of the rename register file; the register file is the slave.
interface rename_reg_file_if;
  import rename_pkg::*;

  logic                         flush;
  logic [NUM_WAYS*2*ARF_AW-1:0] rd_addr;
  logic [NUM_WAYS*2*XLEN-1:0]   rd_data;
  logic [NUM_WAYS*2-1:0]        rd_ready;
  logic [NUM_WAYS-1:0]          map_en;
  logic [NUM_WAYS*ARF_AW-1:0]   map_addr;
  logic [NUM_WAYS*TAG_W-1:0]    map_tag;
  logic [NUM_WAYS-1:0]          map_err;
  logic [NUM_WAYS-1:0]          wr_en;
  logic [NUM_WAYS*TAG_W-1:0]    wr_tag;
  logic [NUM_WAYS*XLEN-1:0]     wr_data;
  logic [NUM_WAYS-1:0]          ret_en;
  logic [NUM_WAYS*TAG_W-1:0]    ret_tag;
  logic [TAG_W:0]               free_count;

  modport master (
    output flush, rd_addr, map_en, map_addr, wr_en, wr_tag, wr_data, ret_en, ret_tag,
    input  rd_data, rd_ready, map_tag, map_err, free_count
  );

  modport slave (
    input  flush, rd_addr, map_en, map_addr, wr_en, wr_tag, wr_data, ret_en, ret_tag,
    output rd_data, rd_ready, map_tag, map_err, free_count
  );
endinterface

// File: rtl/rename_reg_file_picker.sv
// Priority encoder returning the WAYS lowest unallocated RRF indices and whether each exists.
module rrf_free_picker #(
  parameter int DEPTH = 16,
  parameter int WAYS  = 2,
  parameter int IW    = 4
) (
  input  logic [DEPTH-1:0] i_alloc,
  output logic [IW-1:0]    o_idx [WAYS],
  output logic [WAYS-1:0]  o_vld
);
  always_comb begin
    int cnt;
    cnt = 0;
    o_vld = '0;
    for (int k = 0; k < WAYS; k++) o_idx[k] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!i_alloc[i]) begin
        for (int k = 0; k < WAYS; k++) begin
          if (cnt == k) begin
            o_idx[k] = IW'(i);
            o_vld[k] = 1'b1;
          end
        end
        cnt = cnt + 1;
      end
    end
  end
endmodule

// File: rtl/rename_reg_file.sv
// Multi-way ARF + RRF rename register file: operand read, destination map, complete, retire, flush.
module rename_reg_file
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  rename_reg_file_if.slave  bus
);
  localparam logic [TAG_W+1:0] FULL = (TAG_W+2)'(RRF_DEPTH);
  localparam logic [TAG_W+1:0] ONE  = (TAG_W+2)'(1);

  arf_entry_t r_arf [ARF_DEPTH];
  rrf_entry_t r_rrf [RRF_DEPTH];
  logic [TAG_W:0] r_free_count;

  logic [RRF_DEPTH-1:0]       w_alloc;
  logic [TAG_W-1:0]           w_pick_idx [NUM_WAYS];
  logic [NUM_WAYS-1:0]        w_pick_vld;
  logic [ARF_AW-1:0]          w_ra [NUM_WAYS*2];
  logic [NUM_WAYS*2*XLEN-1:0] w_rd_data;
  logic [NUM_WAYS*2-1:0]      w_rd_ready;
  logic [NUM_WAYS-1:0]        w_map_ok, w_map_err, w_ret_ok;
  logic [TAG_W-1:0]           w_map_t [NUM_WAYS];
  logic [ARF_AW-1:0]          w_map_a [NUM_WAYS];
  logic [TAG_W-1:0]           w_ret_t [NUM_WAYS];
  logic [NUM_WAYS*TAG_W-1:0]  w_map_tag;
  logic [TAG_W+1:0]           w_n_map, w_n_ret, w_free_nxt;

  always_comb begin
    for (int i = 0; i < RRF_DEPTH; i++) w_alloc[i] = r_rrf[i].alloc;
  end

  rrf_free_picker #(.DEPTH(RRF_DEPTH), .WAYS(NUM_WAYS), .IW(TAG_W)) u_picker (
    .i_alloc (w_alloc),
    .o_idx   (w_pick_idx),
    .o_vld   (w_pick_vld)
  );

  // Reads see registered state only; a same-cycle complete is visible next cycle.
  always_comb begin
    for (int p = 0; p < NUM_WAYS*2; p++) begin
      w_ra[p] = bus.rd_addr[p*ARF_AW +: ARF_AW];
      w_rd_data[p*XLEN +: XLEN] = '0;
      w_rd_ready[p] = 1'b1;
      if (w_ra[p] != '0) begin
        if (!r_arf[w_ra[p]].busy) begin
          w_rd_data[p*XLEN +: XLEN] = r_arf[w_ra[p]].data;
        end else if (r_rrf[r_arf[w_ra[p]].tag].valid) begin
          w_rd_data[p*XLEN +: XLEN] = r_rrf[r_arf[w_ra[p]].tag].data;
        end else begin
          w_rd_data[p*XLEN +: XLEN] = XLEN'(r_arf[w_ra[p]].tag);
          w_rd_ready[p] = 1'b0;
        end
      end
    end
  end

  // The k-th requesting way (address 0 never requests) takes the k-th lowest free entry.
  always_comb begin
    int req;
    req = 0;
    w_map_ok  = '0;
    w_map_err = '0;
    w_map_tag = '0;
    w_n_map   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_map_a[w] = bus.map_addr[w*ARF_AW +: ARF_AW];
      w_map_t[w] = '0;
      if (bus.map_en[w] && w_map_a[w] != '0) begin
        for (int k = 0; k < NUM_WAYS; k++) begin
          if (req == k && w_pick_vld[k]) begin
            w_map_ok[w] = 1'b1;
            w_map_t[w]  = w_pick_idx[k];
          end
        end
        w_map_err[w] = !w_map_ok[w];
        req = req + 1;
      end
      w_map_tag[w*TAG_W +: TAG_W] = w_map_t[w];
      if (w_map_ok[w]) w_n_map = w_n_map + ONE;
    end
  end

  // A retire needs the entry valid at the start of the cycle; duplicates free the entry once.
  always_comb begin
    w_ret_ok = '0;
    w_n_ret  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      logic dup;
      dup = 1'b0;
      w_ret_t[w]  = bus.ret_tag[w*TAG_W +: TAG_W];
      w_ret_ok[w] = bus.ret_en[w] && r_rrf[w_ret_t[w]].alloc && r_rrf[w_ret_t[w]].valid;
      for (int v = 0; v < w; v++) begin
        if (w_ret_ok[v] && w_ret_t[v] == w_ret_t[w]) dup = 1'b1;
      end
      if (w_ret_ok[w] && !dup) w_n_ret = w_n_ret + ONE;
    end
    w_free_nxt = {1'b0, r_free_count} - w_n_map + w_n_ret;
    if (w_free_nxt > FULL) w_free_nxt = FULL;
  end

  // Update order: complete, retire, map; later writes win, so a same-cycle map keeps dest busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARF_DEPTH; i++) r_arf[i] <= '0;
      for (int i = 0; i < RRF_DEPTH; i++) r_rrf[i] <= '0;
      r_free_count <= (TAG_W+1)'(RRF_DEPTH);
    end else if (bus.flush) begin
      for (int i = 0; i < ARF_DEPTH; i++) r_arf[i].busy <= 1'b0;
      for (int i = 0; i < RRF_DEPTH; i++) begin
        r_rrf[i].alloc <= 1'b0;
        r_rrf[i].valid <= 1'b0;
      end
      r_free_count <= (TAG_W+1)'(RRF_DEPTH);
    end else begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (bus.wr_en[w] && r_rrf[bus.wr_tag[w*TAG_W +: TAG_W]].alloc) begin
          r_rrf[bus.wr_tag[w*TAG_W +: TAG_W]].data  <= bus.wr_data[w*XLEN +: XLEN];
          r_rrf[bus.wr_tag[w*TAG_W +: TAG_W]].valid <= 1'b1;
        end
      end
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (w_ret_ok[w]) begin
          r_arf[r_rrf[w_ret_t[w]].dest].data <= r_rrf[w_ret_t[w]].data;
          if (r_arf[r_rrf[w_ret_t[w]].dest].tag == w_ret_t[w])
            r_arf[r_rrf[w_ret_t[w]].dest].busy <= 1'b0;
          r_rrf[w_ret_t[w]].alloc <= 1'b0;
          r_rrf[w_ret_t[w]].valid <= 1'b0;
        end
      end
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (w_map_ok[w]) begin
          r_rrf[w_map_t[w]].alloc <= 1'b1;
          r_rrf[w_map_t[w]].valid <= 1'b0;
          r_rrf[w_map_t[w]].dest  <= w_map_a[w];
          r_arf[w_map_a[w]].busy  <= 1'b1;
          r_arf[w_map_a[w]].tag   <= w_map_t[w];
        end
      end
      r_free_count <= w_free_nxt[TAG_W:0];
    end
  end

  assign bus.rd_data    = w_rd_data;
  assign bus.rd_ready   = w_rd_ready;
  assign bus.map_tag    = w_map_tag;
  assign bus.map_err    = w_map_err;
  assign bus.free_count = r_free_count;
endmodule
